seqgame_datapath: RTL and testbench

SEQGAME_DATAPATH -- requirements
Module: seqgame_datapath

---
 rtl/seqgame_datapath.sv | 183 ++++++++++++++++++
 tb/tb_seqgame_datapath.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seqgame_datapath.sv
`default_nettype none
// ============================================================================
// Module   : seqgame_datapath
// Brief    : Datapath of a sequence-memory game. It holds banked sequence
//            storage, the item and round counters, press detection and
//            capture, the show and timeout timers, and the score counter.
// Revision : 1.0  initial release
// ============================================================================
module seqgame_datapath #(
  parameter int BTN            = 7,
  parameter int DEPTH          = 16,
  parameter int LEVELS         = 4,
  parameter int SHOW_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES = 200000000,
  parameter int PW             = 3,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [BTN-1:0] buttons,
  input  logic [LW-1:0]  level,
  input  logic           wr_en,
  input  logic [LW-1:0]  wr_level,
  input  logic [AW-1:0]  wr_addr,
  input  logic [BTN-1:0] wr_data,
  input  logic           clear_idx,
  input  logic           next_idx,
  input  logic           clear_round,
  input  logic           next_round,
  input  logic           show_en,
  input  logic           timeout_en,
  input  logic           clear_points,
  input  logic           add_point,
  input  logic [1:0]     out_sel,
  output logic           has_play,
  output logic           correct_play,
  output logic           end_seq,
  output logic           last_round,
  output logic           end_show,
  output logic           half_show,
  output logic           timeout,
  output logic [BTN-1:0] play,
  output logic [PW-1:0]  points
);

  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [AW-1:0] C_IDX_LAST  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] C_SHOW_LAST = SW'(SHOW_CYCLES - 1);
  localparam logic [SW-1:0] C_SHOW_HALF = SW'(SHOW_CYCLES / 2);
  localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [BTN-1:0] r_mem [LEVELS][DEPTH];
  logic [AW-1:0]  r_idx;
  logic [AW-1:0]  r_round;
  logic [BTN-1:0] r_play;
  logic           r_b_any_d;
  logic           r_armed;
  logic           r_has_play;
  logic [SW-1:0]  r_show_cnt;
  logic           r_show_en_d;
  logic [TW-1:0]  r_to_cnt;
  logic [PW-1:0]  r_points;

  logic           w_wr_ok;
  logic           w_lvl_ok;
  logic [BTN-1:0] w_rd;
  logic           w_b_any;
  logic           w_rise;
  logic [SW-1:0]  w_show_cnt;

  // Out-of-range bank/address (non power-of-two sizes) are ignored on write
  // and read back as zero.
  assign w_wr_ok  = ({1'b0, wr_level} < (LW+1)'(LEVELS)) && ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign w_lvl_ok = ({1'b0, level} < (LW+1)'(LEVELS));
  assign w_rd     = w_lvl_ok ? r_mem[level][r_idx] : '0;

  // A press only counts once the buttons have been seen released since
  // reset, so a button held through reset never produces a pulse.
  assign w_b_any = |buttons;
  assign w_rise  = w_b_any & ~r_b_any_d & r_armed;

  // The first show_en cycle is slot position 0 regardless of the held count.
  assign w_show_cnt = (show_en && !r_show_en_d) ? '0 : r_show_cnt;

  // Sequence storage: synchronous write, old data visible during the write cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[l][d] <= '0;
        end
      end
    end else if (wr_en && w_wr_ok) begin
      r_mem[wr_level][wr_addr] <= wr_data;
    end
  end

  // Item index (wrapping) and round length (saturating) counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_round <= '0;
    end else begin
      if (clear_idx)        r_idx <= '0;
      else if (next_idx)    r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
      if (clear_round)      r_round <= '0;
      else if (next_round && r_round != C_IDX_LAST) r_round <= r_round + 1'b1;
    end
  end

  // Press edge detection and capture of the pressed pattern.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_b_any_d  <= 1'b0;
      r_armed    <= 1'b0;
      r_has_play <= 1'b0;
      r_play     <= '0;
    end else begin
      r_b_any_d  <= w_b_any;
      r_armed    <= r_armed | ~w_b_any;
      r_has_play <= w_rise;
      if (w_rise) r_play <= buttons;
    end
  end

  // Show slot timer: wraps while enabled, holds while disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_show_cnt  <= '0;
      r_show_en_d <= 1'b0;
    end else begin
      r_show_en_d <= show_en;
      if (show_en) r_show_cnt <= (w_show_cnt == C_SHOW_LAST) ? '0 : w_show_cnt + 1'b1;
    end
  end

  // Press timeout timer: cleared when disabled or on a press, saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (!timeout_en || r_has_play) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != C_TO_LAST) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Score counter, saturating at all ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_points <= '0;
    end else if (clear_points) begin
      r_points <= '0;
    end else if (add_point && r_points != '1) begin
      r_points <= r_points + 1'b1;
    end
  end

  // Output value selection.
  always_comb begin
    play = '0;
    case (out_sel)
      2'd1:    play = w_rd;
      2'd2:    play = buttons;
      2'd3:    play = r_play;
      default: play = '0;
    endcase
  end

  assign has_play     = r_has_play;
  assign correct_play = (r_play == w_rd);
  assign end_seq      = (r_idx == r_round);
  assign last_round   = (r_round == C_IDX_LAST);
  assign end_show     = show_en && (w_show_cnt == C_SHOW_LAST);
  assign half_show    = (w_show_cnt >= C_SHOW_HALF);
  assign timeout      = (r_to_cnt == C_TO_LAST);
  assign points       = r_points;

endmodule
`default_nettype wire

// File: tb/tb_seqgame_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqgame_datapath
// Brief    : Self-checking bench for seqgame_datapath with a behavioural
//            reference model feeding an expected-response queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_seqgame_datapath;

  localparam int BTN = 7;
  localparam int DEPTH = 16;
  localparam int LEVELS = 4;
  localparam int SHOW = 10;
  localparam int TOUT = 8;
  localparam int PW = 3;
  localparam int AW = 4;
  localparam int LW = 2;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [BTN-1:0] buttons = '0;
  logic [LW-1:0]  level = '0;
  logic           wr_en = 1'b0;
  logic [LW-1:0]  wr_level = '0;
  logic [AW-1:0]  wr_addr = '0;
  logic [BTN-1:0] wr_data = '0;
  logic           clear_idx = 1'b0, next_idx = 1'b0, clear_round = 1'b0, next_round = 1'b0;
  logic           show_en = 1'b0, timeout_en = 1'b0, clear_points = 1'b0, add_point = 1'b0;
  logic [1:0]     out_sel = 2'd0;
  logic           has_play, correct_play, end_seq, last_round, end_show, half_show, timeout;
  logic [BTN-1:0] play;
  logic [PW-1:0]  points;

  seqgame_datapath #(
    .BTN(BTN), .DEPTH(DEPTH), .LEVELS(LEVELS), .SHOW_CYCLES(SHOW),
    .TIMEOUT_CYCLES(TOUT), .PW(PW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .buttons(buttons), .level(level),
    .wr_en(wr_en), .wr_level(wr_level), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_idx(clear_idx), .next_idx(next_idx), .clear_round(clear_round),
    .next_round(next_round), .show_en(show_en), .timeout_en(timeout_en),
    .clear_points(clear_points), .add_point(add_point), .out_sel(out_sel),
    .has_play(has_play), .correct_play(correct_play), .end_seq(end_seq),
    .last_round(last_round), .end_show(end_show), .half_show(half_show),
    .timeout(timeout), .play(play), .points(points)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic           has_play;
    logic           correct_play;
    logic           end_seq;
    logic           last_round;
    logic           end_show;
    logic           half_show;
    logic           timeout;
    logic [BTN-1:0] play;
    logic [PW-1:0]  points;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, expressed as game quantities.
  int m_mem [LEVELS][DEPTH];
  int m_idx, m_round, m_play, m_to, m_points, m_show_pos;
  bit m_has, m_prev, m_armed, m_show_prev;

  task automatic model_reset();
    foreach (m_mem[l, d]) m_mem[l][d] = 0;
    m_idx = 0; m_round = 0; m_play = 0; m_to = 0; m_points = 0; m_show_pos = 0;
    m_has = 0; m_prev = 0; m_armed = 0; m_show_prev = 0;
  endtask

  task automatic idle();
    wr_en = 0; clear_idx = 0; next_idx = 0; clear_round = 0; next_round = 0;
    clear_points = 0; add_point = 0;
  endtask

  // Predict this cycle's outputs, queue them, advance the model over the edge.
  task automatic step();
    exp_t e;
    int   rd, pos;
    bit   any, rise;
    if (!reset_n) model_reset();
    rd  = m_mem[level][m_idx];
    pos = (show_en && !m_show_prev) ? 0 : m_show_pos;
    e.has_play     = m_has;
    e.correct_play = (m_play == rd);
    e.end_seq      = (m_idx == m_round);
    e.last_round   = (m_round == DEPTH - 1);
    e.end_show     = show_en && (pos == SHOW - 1);
    e.half_show    = (pos >= SHOW / 2);
    e.timeout      = (m_to == TOUT - 1);
    case (out_sel)
      2'd0:    e.play = '0;
      2'd1:    e.play = BTN'(rd);
      2'd2:    e.play = buttons;
      default: e.play = BTN'(m_play);
    endcase
    e.points = PW'(m_points);
    q.push_back(e);
    if (reset_n) begin
      any  = (buttons != 0);
      rise = any && !m_prev && m_armed;
      if (rise) m_play = int'(buttons);
      m_armed = m_armed || !any;
      m_prev  = any;
      if (!timeout_en || m_has) m_to = 0;
      else if (m_to < TOUT - 1) m_to++;
      m_has = rise;
      if (show_en) m_show_pos = (pos + 1) % SHOW;
      m_show_prev = show_en;
      if (clear_idx) m_idx = 0;
      else if (next_idx) m_idx = (m_idx + 1) % DEPTH;
      if (clear_round) m_round = 0;
      else if (next_round && m_round < DEPTH - 1) m_round++;
      if (clear_points) m_points = 0;
      else if (add_point && m_points < (1 << PW) - 1) m_points++;
      if (wr_en) m_mem[wr_level][wr_addr] = int'(wr_data);
    end
    @(negedge clock); #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("has_play",     32'(has_play),     32'(e.has_play));
        chk("correct_play", 32'(correct_play), 32'(e.correct_play));
        chk("end_seq",      32'(end_seq),      32'(e.end_seq));
        chk("last_round",   32'(last_round),   32'(e.last_round));
        chk("end_show",     32'(end_show),     32'(e.end_show));
        chk("half_show",    32'(half_show),    32'(e.half_show));
        chk("timeout",      32'(timeout),      32'(e.timeout));
        chk("play",         32'(play),         32'(e.play));
        chk("points",       32'(points),       32'(e.points));
      end
    end
  end

  initial begin
    int hold;
    model_reset();
    @(negedge clock); #1;
    reset_n = 0; out_sel = 2'd3;
    steps(2);
    reset_n = 1;
    steps(2);

    // Stored pattern matched by an identical press, not by a superset press.
    wr_en = 1; wr_level = 1; wr_addr = 0; wr_data = 7'h04;
    step();
    idle(); level = 1; clear_idx = 1;
    step();
    idle(); buttons = 7'h04;
    steps(4);
    buttons = 0; steps(2);
    buttons = 7'h06; steps(3);
    buttons = 0; out_sel = 2'd1; steps(2);

    // Round saturation and index wrap.
    next_round = 1; steps(17);
    idle(); next_idx = 1; steps(16);
    idle(); steps(1);

    // Show timer running, timeout without press, then a press mid-count.
    show_en = 1; timeout_en = 1; steps(12);
    timeout_en = 0; step();
    timeout_en = 1; steps(4);
    buttons = 7'h10; steps(2);
    buttons = 0; steps(6);
    show_en = 0; steps(3);
    show_en = 1; steps(4);

    // Score saturation and clear priority.
    add_point = 1; steps(9);
    clear_points = 1; step();
    idle(); add_point = 1; steps(2);
    idle();

    // Reset while a button is held and counters are non-zero.
    next_idx = 1; next_round = 1; step();
    idle(); buttons = 7'h21; steps(3);
    reset_n = 0; steps(2);
    reset_n = 1; steps(3);
    buttons = 0; steps(2);
    buttons = 7'h02; steps(3);
    buttons = 0; steps(2);

    // Randomised play.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      if (hold == 0) begin
        hold = $urandom_range(1, 6);
        case ($urandom_range(0, 3))
          0, 1:    buttons = '0;
          2:       buttons = BTN'(m_mem[level][m_idx]);
          default: buttons = BTN'($urandom);
        endcase
      end
      hold--;
      wr_en = ($urandom_range(0, 4) == 0);
      wr_level = LW'($urandom); wr_addr = AW'($urandom);
      wr_data = ($urandom_range(0, 1) == 0) ? BTN'(1 << $urandom_range(0, BTN - 1)) : BTN'($urandom);
      if ($urandom_range(0, 9) == 0) level = LW'($urandom);
      out_sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) show_en = ~show_en;
      if ($urandom_range(0, 19) == 0) timeout_en = ~timeout_en;
      clear_idx = ($urandom_range(0, 19) == 0);
      next_idx = ($urandom_range(0, 2) == 0);
      clear_round = ($urandom_range(0, 39) == 0);
      next_round = ($urandom_range(0, 4) == 0);
      clear_points = ($urandom_range(0, 29) == 0);
      add_point = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1; idle();
    steps(2);

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clock);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d expected=0 pending entries", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
